// File: rtl/stall_mem_if.sv
// Data-memory request bus between the memory stage and its responder.
// The initiator holds a request stable until done; stall marks a busy responder.
interface stall_mem_if;
   logic        enable;
   logic        wr;
   logic [15:0] addr;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        stall;
   logic        done;
   logic        err;

   modport master (
      output enable, wr, addr, data_in,
      input  data_out, stall, done, err
   );

   modport slave (
      input  enable, wr, addr, data_in,
      output data_out, stall, done, err
   );
endinterface

// File: rtl/stall_mem_responder.sv
// Fixed-latency data-memory responder: stalls while busy, pulses done on completion.
// Word-aligned 16-bit storage; a misaligned request completes with err and no access.
module stall_mem_responder #(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2
) (
   input  logic       clk,
   input  logic       rst,
   stall_mem_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   logic [1:0]        state;
   logic [3:0]        cnt;
   logic [ADDR_W:0]   addrQ;
   logic              wrQ;
   logic [15:0]       dataQ;
   logic [15:0]       dataOut;
   logic              errQ;
   logic [15:0]       mem [DEPTH];
   logic [ADDR_W-1:0] idx;
   logic              access;
   logic              memWe;
   logic              unusedAddr;

   assign idx    = addrQ[ADDR_W:1];
   assign access = (state == BUSY) && (cnt == 4'd0);
   assign memWe  = access && wrQ && !addrQ[0] && !rst;

   // Upper address bits alias onto the array.
   assign unusedAddr = &{1'b0, bus.addr[15:ADDR_W+1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         dataOut <= 16'd0;
         errQ    <= 1'b0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (bus.enable) begin
                  addrQ <= bus.addr[ADDR_W:0];
                  wrQ   <= bus.wr;
                  dataQ <= bus.data_in;
                  cnt   <= CNT_INIT;
                  state <= BUSY;
               end else begin
                  state <= IDLE;
               end
            end
            BUSY: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  state <= DONE;
                  if (addrQ[0]) begin
                     errQ    <= 1'b1;
                     dataOut <= 16'd0;
                  end else begin
                     errQ <= 1'b0;
                     if (!wrQ) dataOut <= mem[idx];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (memWe) mem[idx] <= dataQ;
   end

   assign bus.stall    = (state == BUSY);
   assign bus.done     = (state == DONE);
   assign bus.err      = errQ;
   assign bus.data_out = dataOut;
endmodule

// File: tb/tb_stall_mem_responder.sv
// Bench for stall_mem_responder: directed and random requests against a word-array model,
// plus latency checks on LATENCY=1 and LATENCY=15 builds.
module tb_stall_mem_responder;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic rst;
   int checks = 0;
   int errors = 0;

   logic [15:0] refMem [256];
   bit          written [256];
   logic [15:0] expData;
   logic        expErr;

   stall_mem_if bus ();
   stall_mem_if b1 ();
   stall_mem_if b15 ();

   stall_mem_responder #(.ADDR_W(8), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   stall_mem_responder #(.ADDR_W(8), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .bus(b1)
   );
   stall_mem_responder #(.ADDR_W(8), .LATENCY(15)) dut15 (
      .clk(clk), .rst(rst), .bus(b15)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic getDone(input int sel);
      if (sel == 1) return b1.done;
      if (sel == 15) return b15.done;
      return bus.done;
   endfunction

   function automatic logic getStall(input int sel);
      if (sel == 1) return b1.stall;
      if (sel == 15) return b15.stall;
      return bus.stall;
   endfunction

   function automatic logic [15:0] getData(input int sel);
      if (sel == 1) return b1.data_out;
      if (sel == 15) return b15.data_out;
      return bus.data_out;
   endfunction

   task automatic setReq(input int sel, input logic en, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
      if (sel == 1) begin
         b1.enable = en; b1.wr = w; b1.addr = a; b1.data_in = d;
      end else if (sel == 15) begin
         b15.enable = en; b15.wr = w; b15.addr = a; b15.data_in = d;
      end else begin
         bus.enable = en; bus.wr = w; bus.addr = a; bus.data_in = d;
      end
   endtask

   // Called just after an accept edge; returns busy-cycle count and edges to done.
   task automatic waitDone(input int sel, input string tag,
                           output int sc, output int cy);
      sc = 0;
      cy = 0;
      while (getDone(sel) !== 1'b1 && cy < 40) begin
         if (getStall(sel) === 1'b1) sc++;
         @(posedge clk); #1;
         cy++;
      end
      check({tag, "_done"}, 32'(getDone(sel)), 32'd1);
   endtask

   // Expected completion of a request, from the addressing rules.
   task automatic model(input logic w, input logic [15:0] a, input logic [15:0] d);
      int i;
      i = (int'(a) / 2) % 256;
      if (a % 2 == 1) begin
         expErr = 1'b1;
         expData = 16'd0;
      end else if (w) begin
         refMem[i] = d;
         written[i] = 1'b1;
         expErr = 1'b0;
      end else begin
         expData = refMem[i];
         expErr = 1'b0;
      end
   endtask

   // One isolated request; inputs are scrambled while the responder is busy.
   task automatic op(input logic w, input logic [15:0] a, input logic [15:0] d,
                     input string tag);
      int sc, cy;
      setReq(0, 1'b1, w, a, d);
      @(posedge clk); #1;
      bus.wr = 1'($urandom);
      bus.addr = 16'($urandom);
      bus.data_in = 16'($urandom);
      waitDone(0, tag, sc, cy);
      check({tag, "_stallw"}, sc, LAT);
      check({tag, "_lat"}, cy, LAT);
      model(w, a, d);
      check({tag, "_err"}, 32'(bus.err), 32'(expErr));
      check({tag, "_data"}, 32'(bus.data_out), 32'(expData));
      bus.enable = 1'b0;
      @(posedge clk); #1;
      check({tag, "_pulse"}, 32'({bus.done, bus.stall}), 32'd0);
   endtask

   task automatic latTest(input int sel, input int lat, input string tag);
      int sc, cy;
      logic [15:0] d;
      d = 16'hA5A5 ^ 16'(lat);
      setReq(sel, 1'b1, 1'b1, 16'h0020, d);
      @(posedge clk); #1;
      waitDone(sel, {tag, "_w"}, sc, cy);
      check({tag, "_wstall"}, sc, lat);
      check({tag, "_wlat"}, cy, lat);
      setReq(sel, 1'b1, 1'b0, 16'h0020, 16'h0);
      @(posedge clk); #1;
      waitDone(sel, {tag, "_r"}, sc, cy);
      check({tag, "_period"}, cy + 1, lat + 1);
      check({tag, "_rdata"}, 32'(getData(sel)), 32'(d));
      setReq(sel, 1'b0, 1'b0, 16'h0, 16'h0);
      @(posedge clk); #1;
   endtask

   initial begin
      int sc, cy;
      logic w;
      logic [15:0] a;
      int i;

      rst = 1'b1;
      setReq(0, 1'b0, 1'b0, 16'h0, 16'h0);
      setReq(1, 1'b0, 1'b0, 16'h0, 16'h0);
      setReq(15, 1'b0, 1'b0, 16'h0, 16'h0);
      expData = 16'd0;
      expErr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_stall", 32'(bus.stall), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      check("rst_data", 32'(bus.data_out), 32'd0);
      rst = 1'b0;

      op(1'b1, 16'h0010, 16'hBEEF, "t1_wr");
      op(1'b0, 16'h0010, 16'h0000, "t1_rd");

      // Back-to-back: enable held through DONE with a new read.
      setReq(0, 1'b1, 1'b0, 16'h0010, 16'h0);
      @(posedge clk); #1;
      waitDone(0, "t2a", sc, cy);
      model(1'b0, 16'h0010, 16'h0);
      check("t2a_data", 32'(bus.data_out), 32'(expData));
      @(posedge clk); #1;
      check("t2_accept", 32'(bus.stall), 32'd1);
      waitDone(0, "t2b", sc, cy);
      check("t2_period", cy + 1, LAT + 1);
      check("t2b_data", 32'(bus.data_out), 32'(expData));
      bus.enable = 1'b0;
      @(posedge clk); #1;

      op(1'b0, 16'h0013, 16'h0000, "t3_mis");
      op(1'b0, 16'h0010, 16'h0000, "t3_rd");

      op(1'b1, 16'h0200, 16'h1234, "t4_wr");
      op(1'b0, 16'h0000, 16'h0000, "t4_alias");
      op(1'b1, 16'h0010, 16'h1234, "t4_wr10");

      // Reset during BUSY aborts the pending write.
      setReq(0, 1'b1, 1'b1, 16'h0010, 16'h5555);
      @(posedge clk); #1;
      check("t5_busy", 32'(bus.stall), 32'd1);
      rst = 1'b1;
      bus.enable = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      check("t5_rst", 32'({bus.stall, bus.done, bus.err}), 32'd0);
      check("t5_data", 32'(bus.data_out), 32'd0);
      expData = 16'd0;
      expErr = 1'b0;
      op(1'b0, 16'h0010, 16'h0000, "t5_rd");

      for (int k = 0; k < 40; k++) begin
         a = 16'($urandom);
         w = 1'($urandom);
         if ($urandom_range(7) != 0) a[0] = 1'b0;
         i = (int'(a) / 2) % 256;
         if (!w && !a[0] && !written[i]) w = 1'b1;
         op(w, a, 16'($urandom), $sformatf("rnd%0d", k));
      end

      latTest(1, 1, "lat1");
      latTest(15, 15, "lat15");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
